earom_store: RTL and testbench

// - Emulates the game's 64x8 electrically-alterable ROM (hiscore store) as on-chip dual-port RAM.
// - Port A serves the CPU's latch/control/read interface and the HPS restore download.
// - Port B is a read-only tap driven by the nvram autosave block's nvram_address.
//   It returns nvram_data_out for hiscore extraction.

---
 rtl/earom_store.sv | 186 ++++++++++++++++++
 tb/tb_earom_store.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/earom_store.sv
// earom_store: 64x8 electrically-alterable ROM emulated as a dual-port RAM.
// Port A serves the CPU latch/control/read interface and the HPS hiscore
// restore download. Port B is an independent registered read tap for the
// nvram autosave block. RAM contents are deliberately left untouched by reset.
module earom_store #(
    parameter int AW        = 6,
    parameter int DUMPINDEX = 4,
    parameter int BUSYCYC   = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_latch_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_ctrl_we,
    input  logic [3:0]    cpu_ctrl,
    output logic [7:0]    cpu_dout,
    output logic          busy,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic [AW-1:0] nvram_address,
    output logic [7:0]    nvram_data_out
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_ER   = 3'd2,
        ST_WRA  = 3'd3,
        ST_WRB  = 3'd4,
        ST_BSY  = 3'd5
    } state_t;

    logic [7:0]    mem [DEPTH];

    state_t        state_q,    state_d;
    logic [AW-1:0] addr_l_q,   addr_l_d;
    logic [7:0]    data_l_q,   data_l_d;
    logic [AW-1:0] op_addr_q,  op_addr_d;
    logic [7:0]    op_data_q,  op_data_d;
    logic [7:0]    wq_q,       wq_d;
    logic [7:0]    count_q,    count_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic [7:0]    nv_q,       nv_d;
    logic          eclk_q,     eclk_d;
    logic          busy_q,     busy_d;

    logic          restore_s;
    logic          fire_s;
    logic [1:0]    mode_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_wa_s;
    logic [7:0]    mem_wd_s;

    // A restore download owns port A; a command needs an eclk rising edge with cs.
    assign restore_s = ioctl_download && (ioctl_index == 8'(DUMPINDEX));
    assign fire_s    = cpu_ctrl_we && cpu_ctrl[0] && !eclk_q && cpu_ctrl[3];
    assign mode_s    = {cpu_ctrl[2], cpu_ctrl[1]};

    // Datapath next values: CPU latches, eclk history, op snapshot, busy counter, read taps.
    always_comb begin
        addr_l_d  = cpu_latch_we ? cpu_addr : addr_l_q;
        data_l_d  = cpu_latch_we ? cpu_din  : data_l_q;
        eclk_d    = cpu_ctrl_we  ? cpu_ctrl[0] : eclk_q;
        op_addr_d = op_addr_q;
        op_data_d = op_data_q;
        count_d   = count_q;
        // the in-flight op works on a snapshot so later latch writes cannot disturb it
        if ((state_q == ST_IDLE) && fire_s && !restore_s) begin
            op_addr_d = addr_l_q;
            op_data_d = data_l_q;
        end else begin
            op_addr_d = op_addr_q;
            op_data_d = op_data_q;
        end
        if ((state_q == ST_ER) || (state_q == ST_WRB)) begin
            count_d = 8'(BUSYCYC - 1);
        end else if ((state_q == ST_BSY) && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end else begin
            count_d = count_q;
        end
        wq_d = (state_q == ST_WRA) ? mem[op_addr_q] : wq_q;
        nv_d = mem[nvram_address];
    end

    // Next-state logic; a restore forces the sequencer back to IDLE.
    always_comb begin
        state_d = state_q;
        if (restore_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fire_s) begin
                        case (mode_s)
                            2'b11:   state_d = ST_RD;
                            2'b10:   state_d = ST_ER;
                            2'b01:   state_d = ST_WRA;
                            default: state_d = ST_IDLE;
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RD:   state_d = ST_IDLE;
                ST_ER:   state_d = ST_BSY;
                ST_WRA:  state_d = ST_WRB;
                ST_WRB:  state_d = ST_BSY;
                ST_BSY:  state_d = (count_q == 8'd0) ? ST_IDLE : ST_BSY;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs and port A write control; the restore path has priority.
    always_comb begin
        busy_d     = restore_s ||
                     (state_d == ST_ER) || (state_d == ST_WRA) ||
                     (state_d == ST_WRB) || (state_d == ST_BSY);
        cpu_dout_d = ((state_q == ST_RD) && !restore_s) ? mem[op_addr_q] : cpu_dout_q;
        mem_we_s   = 1'b0;
        mem_wa_s   = op_addr_q;
        mem_wd_s   = 8'hFF;
        if (restore_s) begin
            mem_we_s = ioctl_wr && (ioctl_addr < 25'(DEPTH));
            mem_wa_s = ioctl_addr[AW-1:0];
            mem_wd_s = ioctl_dout;
        end else if (state_q == ST_ER) begin
            mem_we_s = 1'b1;
            mem_wd_s = 8'hFF;
        end else if (state_q == ST_WRB) begin
            // EAROM programming can only clear bits
            mem_we_s = 1'b1;
            mem_wd_s = wq_q & op_data_q;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_l_q   <= '0;
            data_l_q   <= 8'h00;
            op_addr_q  <= '0;
            op_data_q  <= 8'h00;
            wq_q       <= 8'h00;
            count_q    <= 8'h00;
            cpu_dout_q <= 8'h00;
            nv_q       <= 8'h00;
            eclk_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_l_q   <= addr_l_d;
            data_l_q   <= data_l_d;
            op_addr_q  <= op_addr_d;
            op_data_q  <= op_data_d;
            wq_q       <= wq_d;
            count_q    <= count_d;
            cpu_dout_q <= cpu_dout_d;
            nv_q       <= nv_d;
            eclk_q     <= eclk_d;
            busy_q     <= busy_d;
        end
    end

    // RAM array write port; contents persist across reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_wa_s] <= mem_wd_s;
        end
    end

    assign cpu_dout       = cpu_dout_q;
    assign busy           = busy_q;
    assign nvram_data_out = nv_q;

endmodule

// File: tb/tb_earom_store.sv
// Directed bench for earom_store: erase/write/read, busy timing, ignored
// commands, restore download with index filter, port B sweep, reset mid-write.
module tb_earom_store;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_latch_we = 1'b0;
    logic [5:0]  cpu_addr = 6'd0;
    logic [7:0]  cpu_din = 8'h00;
    logic        cpu_ctrl_we = 1'b0;
    logic [3:0]  cpu_ctrl = 4'd0;
    logic [7:0]  cpu_dout;
    logic        busy;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic [5:0]  nvram_address = 6'd0;
    logic [7:0]  nvram_data_out;

    int n_cmp = 0;
    int n_bad = 0;
    int nb;

    earom_store #(.AW(6), .DUMPINDEX(4), .BUSYCYC(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_latch_we(cpu_latch_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ctrl_we(cpu_ctrl_we), .cpu_ctrl(cpu_ctrl),
        .cpu_dout(cpu_dout), .busy(busy),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .nvram_address(nvram_address), .nvram_data_out(nvram_data_out)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All drive tasks start and end on a falling edge.
    task automatic latch(input logic [5:0] a, input logic [7:0] d);
        cpu_latch_we = 1'b1; cpu_addr = a; cpu_din = d;
        @(negedge clk);
        cpu_latch_we = 1'b0;
    endtask

    task automatic ctrl_pulse(input logic [3:0] c);
        cpu_ctrl_we = 1'b1; cpu_ctrl = c;
        @(negedge clk);
        cpu_ctrl_we = 1'b0;
    endtask

    // Issue a command edge, count busy-high clocks (bounded), then drop eclk.
    task automatic do_cmd(input logic [3:0] c, output int n);
        n = 0;
        ctrl_pulse(c);
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        ctrl_pulse(c & 4'b1110);
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string tag);
        int n;
        latch(a, 8'h00);
        do_cmd(4'b1111, n);
        chk({tag, "_busy"}, n, 0);
        chk(tag, cpu_dout, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("wait_idle_bound", (n < 40) ? 1 : 0, 1);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_dout", cpu_dout, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_nv",   nvram_data_out, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // erase then read
        latch(6'd5, 8'h00);
        do_cmd(4'b1101, nb);
        chk("erase_busy_clks", nb, 9);
        rd(6'd5, 8'hFF, "erase_read");

        // write-AND twice
        latch(6'd5, 8'h3C);
        do_cmd(4'b1011, nb);
        chk("write1_busy_clks", nb, 10);
        latch(6'd5, 8'hF0);
        do_cmd(4'b1011, nb);
        chk("write2_busy_clks", nb, 10);
        rd(6'd5, 8'h30, "write_and_read");

        // read command during an erase is ignored; latch change mid-op is harmless
        latch(6'd9, 8'h00);
        ctrl_pulse(4'b1101);
        latch(6'd5, 8'h00);
        ctrl_pulse(4'b1100);
        ctrl_pulse(4'b1111);
        ctrl_pulse(4'b1110);
        wait_idle();
        chk("ignored_read_dout", cpu_dout, 8'h30);
        rd(6'd5, 8'h30, "erase_hit_snapshot_addr");
        rd(6'd9, 8'hFF, "erase_addr9");

        // mode 00 edge and cs=0 edge do nothing
        ctrl_pulse(4'b1001);
        chk("mode00_busy", busy, 1'b0);
        ctrl_pulse(4'b1000);
        latch(6'd5, 8'h00);
        ctrl_pulse(4'b0101);
        chk("cs0_busy", busy, 1'b0);
        ctrl_pulse(4'b0000);
        rd(6'd5, 8'h30, "cs0_no_erase");

        // restore download, index 4, plus out-of-range address 64
        ioctl_index = 8'd4; ioctl_download = 1'b1;
        @(negedge clk);
        chk("restore_busy", busy, 1'b1);
        for (int a = 0; a < 65; a++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = 8'(a) ^ 8'hA5;
            if (a == 64) ioctl_dout = 8'h11;
            @(negedge clk);
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("restore_busy_clear", busy, 1'b0);
        rd(6'd0, 8'hA5, "restore_mem0");
        rd(6'd63, 8'h9A, "restore_mem63");

        // port B sweep at one clock latency
        for (int a = 0; a < 64; a++) begin
            nvram_address = 6'(a);
            @(negedge clk);
            chk("portb_sweep", nvram_data_out, 8'(a) ^ 8'hA5);
        end

        // wrong index leaves RAM alone
        ioctl_index = 8'd3; ioctl_download = 1'b1;
        ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h00;
        @(negedge clk);
        chk("idx3_not_busy", busy, 1'b0);
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        rd(6'd0, 8'hA5, "idx3_unchanged");

        // restore aborts a write that is in WRA
        latch(6'd10, 8'h00);
        ctrl_pulse(4'b1011);
        ioctl_index = 8'd4; ioctl_download = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ioctl_download = 1'b0;
        ctrl_pulse(4'b1010);
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        rd(6'd10, 8'hAF, "abort_no_write");

        // reset during WRA
        latch(6'd12, 8'h00);
        ctrl_pulse(4'b1011);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_dout", cpu_dout, 8'h00);
        @(negedge clk);
        cpu_ctrl = 4'd0;
        reset_n = 1'b1;
        @(negedge clk);
        rd(6'd12, 8'hA9, "rst_mid_mem_kept");
        rd(6'd0, 8'hA5, "rst_mem0_kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
